alu_issue: RTL and testbench
============================

# alu_issue

Execute-stage issue register feeding the ALU. It accepts one decoded instruction per handshake (ALUOp, funct7, funct3, operands) and encodes it into the ALU's 3-bit control code. It registers the code and selected operands toward the ALU, and holds multiply operations for a programmable number of cycles so the combinational multiplier can be constrained as a multicycle path. It sits between the ID/EX boundary and the ALU and provides valid/ready flow control plus a synchronous flush.

## Interface
- MUL_CYCLES, 3, cycles a MUL occupies the ALU before its result is valid; legal 1..15
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous kill of held/pending operation
- in_valid_i  in  1  decoded instruction present
- in_ready_o  out  1  block accepts this cycle
- ALUOp_i  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type ALU
- funct7_i  in  7  instruction funct7
- funct3_i  in  3  instruction funct3
- rs1_data_i  in  32  register operand 1
- rs2_data_i  in  32  register operand 2
- imm_i  in  32  sign-extended immediate
- ALUSrc_i  in  1  1 selects imm_i as operand 2
- out_valid_o  out  1  ALUCtrl_o/data*_o valid for ALU consumption
- out_ready_i  in  1  downstream (EX/MEM) accepts result
- ALUCtrl_o  out  3  ALU control code
- data1_o  out  32  ALU operand 1
- data2_o  out  32  ALU operand 2
- illegal_o  out  1  held operation was unsupported; qualified by out_valid_o

## Operation
- ALU codes: add 000, sub 001, mul 010, xor 011, sll 100, srai 101, and 110.
- Decode: ALUOp 00 → add; 01 → sub.
- ALUOp 10, funct3 000: funct7 0000000 add, 0100000 sub, 0000001 mul.
- ALUOp 10, other funct3: 111/0000000 and; 100/0000000 xor; 001/0000000 sll.
- ALUOp 11: funct3 000 addi → add; funct3 101 with funct7 0100000 → srai.
- Any other combination: code 000, illegal_o=1, operands still forwarded.
- Operand selection: data1_o=rs1_data_i; data2_o = ALUSrc_i ? imm_i : rs2_data_i.
- States:
  - IDLE: nothing held.
  - HOLD: output valid.
  - MUL_WAIT: mul held, 4-bit counter running.
- Accept when in_valid_i && in_ready_o.
- in_ready_o = !flush_i && (IDLE || (HOLD && out_ready_i)); it is 0 in MUL_WAIT.
- On accept, capture code, operands and illegal flag.
- Transition on accept:
  - non-mul, or mul with MUL_CYCLES=1 → HOLD;
  - otherwise → MUL_WAIT with counter = MUL_CYCLES-2.
- MUL_WAIT: decrement counter each cycle; when counter==0 → HOLD.
- HOLD with out_ready_i and no new accept → IDLE; with accept → back-to-back reload (HOLD or MUL_WAIT).
- flush_i, any state: next state IDLE, out_valid_o=0 next cycle, no accept that cycle; flush beats simultaneous in_valid_i and out_ready_i.
- Output registers hold their value while not loading; out_valid_o=1 only in HOLD.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, counter 0, out_valid_o 0, ALUCtrl_o 000, data1_o/data2_o 0, illegal_o 0; in_ready_o 1 after reset unless flush_i is high.
- Non-mul latency: accept at edge t → out_valid_o high in cycle t+1.
- Mul latency: out_valid_o high from cycle t+MUL_CYCLES; ALUCtrl_o/data*_o stable from t+1 for the multicycle path.
- Throughput: 1 op/cycle for non-mul with out_ready_i held high; mul blocks new accepts for MUL_CYCLES cycles.
- Outputs never change while out_valid_o=1 and out_ready_i=0.
- Reset asserted mid-MUL_WAIT: immediate return to reset values.

## Structure
- Package alu_pkg: ALU control code localparams, ALUOp codes, funct7 constants (BASE 0000000, ALT 0100000, MULDIV 0000001), state enum.
- Sub-module alu_ctrl_decode: purely combinational ALUOp/funct7/funct3 → {code, illegal}; instantiated once, unit-testable alone.

## Test plan
- Reset mid-stream: assert rst_i low during MUL_WAIT → all outputs 0, state IDLE, in_ready_o=1 after release.
- R-type sub: ALUOp 10, funct7 0100000, funct3 000, rs1=9, rs2=4, out_ready_i=1 → next cycle ALUCtrl_o=001, data1_o=9, data2_o=4, out_valid_o=1.
- I-type srai: ALUOp 11, funct3 101, funct7 0100000, ALUSrc_i=1, imm=3 → ALUCtrl_o=101, data2_o=3. Back-to-back 8 adds → 8 consecutive valid cycles.
- MUL, MUL_CYCLES=3: accept at t → out_valid_o 0 at t+1,t+2, 1 at t+3; in_ready_o 0 until HOLD; repeat with MUL_CYCLES=1 → valid at t+1.
- Backpressure: out_ready_i=0 for 5 cycles in HOLD → outputs stable, in_ready_o=0; release → accept next op same cycle.
- Illegal (ALUOp 10, funct3 010) → illegal_o=1, ALUCtrl_o=000. flush_i during MUL_WAIT with in_valid_i=1 → out_valid_o=0 next cycle, input not accepted.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants and types for the ALU issue register and its control decoder.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_MUL  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SRAI = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;

    localparam logic [1:0] ALUOP_LDST   = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_MUL_WAIT
    } state_e;

endpackage

// File: rtl/alu_issue_if.sv
// Handshake and datapath bundle between ID/EX, the issue register and the ALU.
interface alu_issue_if;

    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [1:0]  ALUOp_i;
    logic [6:0]  funct7_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic        ALUSrc_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [2:0]  ALUCtrl_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic        illegal_o;

    modport slave (
        input  flush_i, in_valid_i, ALUOp_i, funct7_i, funct3_i,
               rs1_data_i, rs2_data_i, imm_i, ALUSrc_i, out_ready_i,
        output in_ready_o, out_valid_o, ALUCtrl_o, data1_o, data2_o, illegal_o
    );

    modport master (
        output flush_i, in_valid_i, ALUOp_i, funct7_i, funct3_i,
               rs1_data_i, rs2_data_i, imm_i, ALUSrc_i, out_ready_i,
        input  in_ready_o, out_valid_o, ALUCtrl_o, data1_o, data2_o, illegal_o
    );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct7/funct3 to 3-bit ALU control code, flagging unsupported encodings.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp_i,
    input  logic [6:0] funct7_i,
    input  logic [2:0] funct3_i,
    output logic [2:0] code_o,
    output logic       illegal_o
);

    always_comb begin
        code_o    = ALU_ADD;
        illegal_o = 1'b0;
        unique case (ALUOp_i)
            ALUOP_LDST:   code_o = ALU_ADD;
            ALUOP_BRANCH: code_o = ALU_SUB;
            ALUOP_RTYPE: begin
                if (funct3_i == F3_ADD && funct7_i == F7_BASE)        code_o = ALU_ADD;
                else if (funct3_i == F3_ADD && funct7_i == F7_ALT)    code_o = ALU_SUB;
                else if (funct3_i == F3_ADD && funct7_i == F7_MULDIV) code_o = ALU_MUL;
                else if (funct3_i == F3_AND && funct7_i == F7_BASE)   code_o = ALU_AND;
                else if (funct3_i == F3_XOR && funct7_i == F7_BASE)   code_o = ALU_XOR;
                else if (funct3_i == F3_SLL && funct7_i == F7_BASE)   code_o = ALU_SLL;
                else                                                  illegal_o = 1'b1;
            end
            ALUOP_ITYPE: begin
                // addi carries immediate bits in funct7, so only funct3 is decoded
                if (funct3_i == F3_ADD)                           code_o = ALU_ADD;
                else if (funct3_i == F3_SR && funct7_i == F7_ALT) code_o = ALU_SRAI;
                else                                              illegal_o = 1'b1;
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue.sv
// Issue register ahead of the ALU: decodes, registers operands and holds MUL for a multicycle path.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    alu_issue_if.slave    bus
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] d1_q, d1_d;
    logic [31:0] d2_q, d2_d;
    logic        ill_q, ill_d;

    logic [2:0]  dec_code;
    logic        dec_illegal;
    logic        accept;

    alu_ctrl_decode u_decode (
        .ALUOp_i   (bus.ALUOp_i),
        .funct7_i  (bus.funct7_i),
        .funct3_i  (bus.funct3_i),
        .code_o    (dec_code),
        .illegal_o (dec_illegal)
    );

    assign bus.in_ready_o = !bus.flush_i &&
                            (state_q == S_IDLE || (state_q == S_HOLD && bus.out_ready_i));
    assign accept         = bus.in_valid_i && bus.in_ready_o;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        ill_d   = ill_q;
        if (bus.flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (accept) begin
            ctrl_d = dec_code;
            d1_d   = bus.rs1_data_i;
            d2_d   = bus.ALUSrc_i ? bus.imm_i : bus.rs2_data_i;
            ill_d  = dec_illegal;
            if (dec_code == ALU_MUL && MUL_CYCLES > 1) begin
                state_d = S_MUL_WAIT;
                cnt_d   = 4'(MUL_CYCLES - 2);
            end else begin
                state_d = S_HOLD;
            end
        end else begin
            unique case (state_q)
                S_HOLD: if (bus.out_ready_i) state_d = S_IDLE;
                S_MUL_WAIT: begin
                    if (cnt_q == '0) state_d = S_HOLD;
                    else             cnt_d   = cnt_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= ALU_ADD;
            d1_q    <= '0;
            d2_q    <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.out_valid_o = (state_q == S_HOLD);
    assign bus.ALUCtrl_o   = ctrl_q;
    assign bus.data1_o     = d1_q;
    assign bus.data2_o     = d2_q;
    assign bus.illegal_o   = ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: one instance with MUL_CYCLES=3, one with MUL_CYCLES=1.
module tb_alu_issue;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk_i = ~clk_i;

    alu_issue_if a ();
    alu_issue_if b ();

    alu_issue #(.MUL_CYCLES(3)) dut3 (.clk_i(clk_i), .rst_i(rst_i), .bus(a));
    alu_issue #(.MUL_CYCLES(1)) dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [1:0] op, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] im, input logic src, input logic ordy);
        a.in_valid_i  = v;
        a.ALUOp_i     = op;
        a.funct7_i    = f7;
        a.funct3_i    = f3;
        a.rs1_data_i  = r1;
        a.rs2_data_i  = r2;
        a.imm_i       = im;
        a.ALUSrc_i    = src;
        a.out_ready_i = ordy;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] c,
                             input logic [31:0] x1, input logic [31:0] x2, input logic il);
        check({tag, ".valid"}, 32'(a.out_valid_o), 32'(v));
        check({tag, ".ctrl"},  32'(a.ALUCtrl_o),   32'(c));
        check({tag, ".d1"},    a.data1_o, x1);
        check({tag, ".d2"},    a.data2_o, x2);
        check({tag, ".ill"},   32'(a.illegal_o),   32'(il));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a.flush_i = 1'b0;
        drive_a(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        b.flush_i = 1'b0; b.in_valid_i = 1'b0; b.ALUOp_i = 2'b00; b.funct7_i = 7'h00;
        b.funct3_i = 3'b000; b.rs1_data_i = '0; b.rs2_data_i = '0; b.imm_i = '0;
        b.ALUSrc_i = 1'b0; b.out_ready_i = 1'b1;

        // reset values
        repeat (2) @(negedge clk_i);
        check_out("reset", 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        check("reset.ready", 32'(a.in_ready_o), 32'd1);
        rst_i = 1'b1;

        // R-type sub
        @(negedge clk_i);
        drive_a(1'b1, 2'b10, 7'b0100000, 3'b000, 32'd9, 32'd4, 32'd100, 1'b0, 1'b1);
        #1 check("sub.ready", 32'(a.in_ready_o), 32'd1);
        @(negedge clk_i);
        check_out("sub", 1'b1, 3'b001, 32'd9, 32'd4, 1'b0);

        // I-type srai takes immediate as operand 2
        drive_a(1'b1, 2'b11, 7'b0100000, 3'b101, 32'h80, 32'd77, 32'd3, 1'b1, 1'b1);
        @(negedge clk_i);
        check_out("srai", 1'b1, 3'b101, 32'h80, 32'd3, 1'b0);

        // 8 back-to-back adds
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 2'b00, 7'h00, 3'b010, 32'(i + 16), 32'd100, 32'd0, 1'b0, 1'b1);
            @(negedge clk_i);
            check($sformatf("b2b%0d.valid", i), 32'(a.out_valid_o), 32'd1);
            check($sformatf("b2b%0d.d1", i), a.data1_o, 32'(i + 16));
        end
        drive_a(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        check("drain.valid", 32'(a.out_valid_o), 32'd0);

        // MUL with MUL_CYCLES=3
        drive_a(1'b1, 2'b10, 7'b0000001, 3'b000, 32'd6, 32'd7, 32'd0, 1'b0, 1'b1);
        @(negedge clk_i);
        drive_a(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        #1 check_out("mul_t1", 1'b0, 3'b010, 32'd6, 32'd7, 1'b0);
        check("mul_t1.ready", 32'(a.in_ready_o), 32'd0);
        @(negedge clk_i);
        check("mul_t2.valid", 32'(a.out_valid_o), 32'd0);
        check("mul_t2.ready", 32'(a.in_ready_o), 32'd0);
        @(negedge clk_i);
        check_out("mul_t3", 1'b1, 3'b010, 32'd6, 32'd7, 1'b0);
        check("mul_t3.ready", 32'(a.in_ready_o), 32'd1);
        @(negedge clk_i);
        check("mul_done.valid", 32'(a.out_valid_o), 32'd0);

        // MUL with MUL_CYCLES=1
        b.in_valid_i = 1'b1; b.ALUOp_i = 2'b10; b.funct7_i = 7'b0000001; b.funct3_i = 3'b000;
        b.rs1_data_i = 32'd5; b.rs2_data_i = 32'd8;
        @(negedge clk_i);
        b.in_valid_i = 1'b0;
        check("mul1.valid", 32'(b.out_valid_o), 32'd1);
        check("mul1.ctrl", 32'(b.ALUCtrl_o), 32'(3'b010));
        check("mul1.d2", b.data2_o, 32'd8);

        // backpressure on xor, with an and waiting at the input
        drive_a(1'b1, 2'b10, 7'h00, 3'b100, 32'hF0, 32'h0F, 32'h0, 1'b0, 1'b0);
        @(negedge clk_i);
        drive_a(1'b1, 2'b10, 7'h00, 3'b111, 32'h55, 32'h33, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1 check_out($sformatf("bp%0d", i), 1'b1, 3'b011, 32'hF0, 32'h0F, 1'b0);
            check($sformatf("bp%0d.ready", i), 32'(a.in_ready_o), 32'd0);
            @(negedge clk_i);
        end
        a.out_ready_i = 1'b1;
        #1 check("bp_rel.ready", 32'(a.in_ready_o), 32'd1);
        @(negedge clk_i);
        check_out("and", 1'b1, 3'b110, 32'h55, 32'h33, 1'b0);

        // illegal R-type funct3 010
        drive_a(1'b1, 2'b10, 7'h00, 3'b010, 32'h11, 32'h22, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        check_out("illegal", 1'b1, 3'b000, 32'h11, 32'h22, 1'b0 ^ 1'b1);
        // srli-like encoding is unsupported too; forwards immediate
        drive_a(1'b1, 2'b11, 7'h00, 3'b101, 32'h12, 32'h0, 32'h7, 1'b1, 1'b1);
        @(negedge clk_i);
        check_out("illegal_i", 1'b1, 3'b000, 32'h12, 32'h7, 1'b1);
        drive_a(1'b1, 2'b01, 7'h00, 3'b000, 32'h13, 32'h14, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        check_out("branch", 1'b1, 3'b001, 32'h13, 32'h14, 1'b0);
        drive_a(1'b0, 2'b00, 7'h00, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);

        // flush during MUL_WAIT with a competing valid input
        drive_a(1'b1, 2'b10, 7'b0000001, 3'b000, 32'h21, 32'h22, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        drive_a(1'b1, 2'b00, 7'h00, 3'b000, 32'hAA, 32'hBB, 32'h0, 1'b0, 1'b1);
        a.flush_i = 1'b1;
        #1 check("flush.ready", 32'(a.in_ready_o), 32'd0);
        @(negedge clk_i);
        check("flush.valid", 32'(a.out_valid_o), 32'd0);
        a.flush_i = 1'b0;
        a.in_valid_i = 1'b0;
        @(negedge clk_i);
        check_out("flush_after", 1'b0, 3'b010, 32'h21, 32'h22, 1'b0);
        check("flush_after.ready", 32'(a.in_ready_o), 32'd1);

        // asynchronous reset while in MUL_WAIT
        drive_a(1'b1, 2'b10, 7'b0000001, 3'b000, 32'h31, 32'h32, 32'h0, 1'b0, 1'b1);
        @(negedge clk_i);
        a.in_valid_i = 1'b0;
        #2 rst_i = 1'b0;
        #1 check_out("rst_mid", 1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        check("rst_mid.ready", 32'(a.in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_rel.valid", 32'(a.out_valid_o), 32'd0);
        check("rst_rel.ready", 32'(a.in_ready_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
